// File: rtl/clint_pkg.sv
// Shared constants and types for the core-local interruptor: register offsets,
// reset values and the register-select encoding produced by the address decode.
package clint_pkg;

  localparam logic [15:0] MSIP_OFF        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MTIME_RST    = 64'h0000_0000_0000_0000;

  typedef enum logic [2:0] {
    SEL_NONE    = 3'd0,
    SEL_MSIP    = 3'd1,
    SEL_CMP_LO  = 3'd2,
    SEL_CMP_HI  = 3'd3,
    SEL_TIME_LO = 3'd4,
    SEL_TIME_HI = 3'd5
  } reg_sel_e;

endpackage

// File: rtl/clint_timer_if.sv
// Request/response bus between the core's data-side master and the CLINT slave.
interface clint_timer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/clint_prescaler.sv
// Divides the core clock by TICK_DIV: o_tick is high for one cycle each time the
// counter sits at TICK_DIV-1, after which the counter wraps to 0.
module clint_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] r_cnt;

  assign o_tick = (r_cnt == LAST);

  // Free-running divide counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 16'd0;
    end else if (o_tick) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: mtime/mtimecmp/msip register bank behind a one-deep bus.
// Optional CLINT_MTIME_SNAPSHOT_EN adds a shadow of mtime_hi captured on mtime_lo reads.
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic           clk,
  input  logic           reset,
  clint_timer_if.slave   bus,
  output logic           soft_pending,
  output logic           time_pending,
  output logic [63:0]    mtime_o
);

  logic        w_tick;
  logic        w_accept;
  logic        w_wr;
  reg_sel_e    w_sel;
  logic [31:0] w_rdata;

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic        r_time_pending;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
`ifdef CLINT_MTIME_SNAPSHOT_EN
  logic [31:0] r_shadow;
`endif

  clint_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .o_tick (w_tick)
  );

  assign bus.req_ready = ~r_resp_valid | bus.resp_ready;
  assign w_accept      = bus.req_valid & bus.req_ready;
  assign w_wr          = w_accept & bus.req_we;

  // Address decode: base match and word alignment gate every register hit
  always_comb begin
    w_sel = SEL_NONE;
    if ((bus.req_addr[31:16] == BASE_ADDR[31:16]) && (bus.req_addr[1:0] == 2'b00)) begin
      case (bus.req_addr[15:0])
        MSIP_OFF:        w_sel = SEL_MSIP;
        MTIMECMP_LO_OFF: w_sel = SEL_CMP_LO;
        MTIMECMP_HI_OFF: w_sel = SEL_CMP_HI;
        MTIME_LO_OFF:    w_sel = SEL_TIME_LO;
        MTIME_HI_OFF:    w_sel = SEL_TIME_HI;
        default:         w_sel = SEL_NONE;
      endcase
    end else begin
      w_sel = SEL_NONE;
    end
  end

  // Read mux over the register values present at the accept edge
  always_comb begin
    w_rdata = 32'd0;
    case (w_sel)
      SEL_MSIP:    w_rdata = {31'd0, r_msip};
      SEL_CMP_LO:  w_rdata = r_mtimecmp[31:0];
      SEL_CMP_HI:  w_rdata = r_mtimecmp[63:32];
      SEL_TIME_LO: w_rdata = r_mtime[31:0];
`ifdef CLINT_MTIME_SNAPSHOT_EN
      SEL_TIME_HI: w_rdata = r_shadow;
`else
      SEL_TIME_HI: w_rdata = r_mtime[63:32];
`endif
      default:     w_rdata = 32'd0;
    endcase
  end

  // mtime: a software write to either half suppresses that cycle's increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mtime <= MTIME_RST;
    end else if (w_wr && (w_sel == SEL_TIME_LO)) begin
      r_mtime <= {r_mtime[63:32], bus.req_wdata};
    end else if (w_wr && (w_sel == SEL_TIME_HI)) begin
      r_mtime <= {bus.req_wdata, r_mtime[31:0]};
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  // mtimecmp, msip and the registered timer compare
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mtimecmp     <= MTIMECMP_RST;
      r_msip         <= 1'b0;
      r_time_pending <= 1'b0;
    end else begin
      r_time_pending <= (r_mtime >= r_mtimecmp);
      if (w_wr && (w_sel == SEL_CMP_LO)) begin
        r_mtimecmp[31:0] <= bus.req_wdata;
      end
      if (w_wr && (w_sel == SEL_CMP_HI)) begin
        r_mtimecmp[63:32] <= bus.req_wdata;
      end
      if (w_wr && (w_sel == SEL_MSIP)) begin
        r_msip <= bus.req_wdata[0];
      end
    end
  end

`ifdef CLINT_MTIME_SNAPSHOT_EN
  // Shadow of the upper half so a lo-then-hi read pair cannot tear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow <= 32'd0;
    end else if (w_accept && !bus.req_we && (w_sel == SEL_TIME_LO)) begin
      r_shadow <= r_mtime[63:32];
    end else if (w_wr && (w_sel == SEL_TIME_HI)) begin
      r_shadow <= bus.req_wdata;
    end
  end
`endif

  // Response register: held until consumed, loaded on every accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else if (w_accept) begin
      r_resp_valid <= 1'b1;
      r_resp_rdata <= bus.req_we ? 32'd0 : w_rdata;
      r_resp_err   <= (w_sel == SEL_NONE);
    end else if (bus.resp_ready) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end
  end

  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign soft_pending   = r_msip;
  assign time_pending   = r_time_pending;
  assign mtime_o        = r_mtime;

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Core-local interruptor: the memory-mapped source of the machine timer and software interrupt pending lines.
- Its time_pending and soft_pending outputs feed the CSR file's pending inputs, which drive mip bits 7 and 3.
- Sits on the core's data-side peripheral bus. It holds the 64-bit mtime counter, the 64-bit mtimecmp compare register and the msip register.
- Software programs it with ordinary loads and stores.

Parameters:
- TICK_DIV, default 1: core clocks per mtime increment. Legal range 1..65535. A value of 1 means mtime increments every cycle.
- BASE_ADDR, default 32'h0200_0000: base address; req_addr[31:16] must equal BASE_ADDR[31:16].

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset. It is the block's only reset.
- req_valid  in  1  bus request valid.
- req_ready  out  1  bus request accepted when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address, word aligned.
- req_wdata  in  32  write data.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumed when resp_valid && resp_ready.
- resp_rdata  out  32  read data. Forced to 0 on writes and errors.
- resp_err  out  1  unmapped or misaligned access.
- soft_pending  out  1  machine software interrupt pending.
- time_pending  out  1  machine timer interrupt pending.
- mtime_o  out  64  current mtime value, for trace and debug.

Behaviour:
- Register map (offsets from BASE_ADDR):
  - 0x0000 msip: bit 0 only, other bits read 0.
  - 0x4000 mtimecmp_lo.
  - 0x4004 mtimecmp_hi.
  - 0xBFF8 mtime_lo.
  - 0xBFFC mtime_hi.
  - Any other offset, or req_addr[1:0] != 0, gives resp_err=1 with no state change.
- Reset values:
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0, prescaler = 0.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - soft_pending = 0, time_pending = 0.
  - req_ready = 1 out of reset.
- Handshake: one outstanding transaction.
  - req_ready = ~resp_valid | resp_ready.
  - An accepted request produces resp_valid on the next cycle.
  - resp_valid, resp_rdata and resp_err are held stable until resp_ready.
  - Back-to-back accepts give one response per cycle when resp_ready is held high.
- Writes take effect at the accept edge. Reads sample the register value present at the accept edge.
- Prescaler:
  - Counts 0..TICK_DIV-1. A tick fires on the cycle it equals TICK_DIV-1, then it wraps to 0.
  - On a tick, mtime <= mtime + 1. 64-bit wrap: FFFF_FFFF_FFFF_FFFF -> 0.
- Write precedence:
  - A write to mtime_lo or mtime_hi in a tick cycle wins; no increment that cycle, for either half.
  - A write to mtime_lo never carries into mtime_hi.
  - A write to mtime does not reset the prescaler.
- time_pending:
  - Registered: time_pending <= (mtime >= mtimecmp), unsigned 64-bit, using current register values.
  - It therefore follows a change of either register by exactly 1 cycle.
  - It stays high while the condition holds and clears 1 cycle after mtimecmp is raised above mtime.
- soft_pending = msip[0], registered. Set and clear only by writes to msip.
- Reset asserted mid-transaction:
  - Any pending response is dropped and resp_valid = 0.
  - All registers return to their reset values asynchronously.
- mtime_o is the mtime register value, combinational from the flop.

Optional Feature:
- Macro CLINT_MTIME_SNAPSHOT_EN.
- When defined:
  - A read of mtime_lo also captures mtime[63:32] into a 32-bit shadow register.
  - The next read of mtime_hi returns the shadow, so a lo-then-hi read sequence is tear-free.
  - Writes to mtime_hi also update the shadow.
  - Shadow reset value is 0.
- When undefined: mtime_hi reads return the live value; there is no shadow flop.

Decomposition:
- Package clint_pkg:
  - Register offset constants: MSIP_OFF, MTIMECMP_LO_OFF, MTIMECMP_HI_OFF, MTIME_LO_OFF, MTIME_HI_OFF.
  - Reset constants: MTIMECMP_RST, MTIME_RST.
  - Register-select enum used by the decode.
- One sub-module, clint_prescaler: parameterised TICK_DIV counter that emits a single-cycle tick pulse; async active-high reset.
- Decode, the register bank and the response logic stay in clint_timer.

Test Plan:
- Reset, then read mtimecmp_hi -> 32'hFFFFFFFF. time_pending=0, soft_pending=0.
- TICK_DIV=1. Write mtimecmp_lo=10 and mtimecmp_hi=0 while mtime counts from 0 -> time_pending rises the cycle after mtime==10. Then write mtimecmp_lo=100 -> time_pending falls 1 cycle after the accept.
- TICK_DIV=4 -> mtime_o advances by 1 every 4 clocks. Over 40 clocks after reset, mtime_o == 10.
- Write mtime_lo=32'hFFFFFFFF and mtime_hi=32'hFFFFFFFF -> after one tick, mtime_o == 0. Also write mtime_lo=32'hFFFFFFFF on a tick cycle -> mtime_hi is unchanged.
- Write msip=32'hFFFFFFFF -> soft_pending=1 and a read of msip returns 32'h1. A read of offset 0x0008 -> resp_err=1, rdata 0.
- Hold resp_ready=0 for 3 cycles after a read -> req_ready=0 and response fields held stable. Assert reset during the hold -> resp_valid=0 immediately. With CLINT_MTIME_SNAPSHOT_EN, read lo at mtime=0x0000_0000_FFFF_FFFF, tick, then read hi -> 0.
